fir_mac_engine: RTL and testbench
=================================

Name: fir_mac_engine

Overview:
- Datapath stage directly downstream of the FIR streamer.
- Consumes the 16-bit x (sample) and h (coefficient) HWPE-Streams jointly, one pair per cycle.
- Multiply-accumulates NB_TAPS pairs per output sample, then shifts, optionally rounds, and saturates the result.
- Emits one 16-bit y sample per window on the y HWPE-Stream back into the streamer.
- Controlled by the FIR controller through a start/config port; reports busy and done.

Parameters:
- DATA_WIDTH, 16, width of x, h and y stream data (signed two's complement).
- ACC_WIDTH, 40, accumulator width (signed); must be >= 2*DATA_WIDTH.
- CNT_WIDTH, 16, width of the tap and output counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- enable_i  in  1  when 0, all registers hold and no handshakes fire.
- start_i  in  1  one-cycle pulse; latches the config and begins the job.
- nb_taps_i  in  CNT_WIDTH  pairs per output sample.
- nb_outputs_i  in  CNT_WIDTH  output samples per job.
- shift_i  in  5  right-shift amount applied to the accumulator.
- x_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  sample stream.
- h_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  coefficient stream.
- y_o  hwpe_stream_intf_stream.source  DATA_WIDTH  result stream.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle pulse at job end.

Behaviour:
- Reset/clear: state=IDLE; acc, product register, counters = 0; y_o.valid=0, y_o.data=0, y_o.strb=all ones, x_i.ready=h_i.ready=0, busy_o=0, done_o=0.
- Clear mid-operation: job aborts with no done pulse; partial accumulator discarded.
- FSM states: IDLE, ACC, DRAIN, OUT.
- IDLE:
  - start_i latches nb_taps, nb_outputs and shift; clears acc and both counters; goes to ACC.
  - If latched nb_taps==0 or nb_outputs==0: no stream traffic; done_o pulses the next cycle; stays IDLE.
  - start_i outside IDLE is ignored.
- ACC:
  - Fire = x_i.valid & h_i.valid & enable_i; x_i.ready = h_i.ready = Fire (joint consume, never one without the other).
  - On fire: prod_q <= signed x*h (2*DATA_WIDTH bits, registered, stage 1); tap_cnt++.
  - prod_valid_q sign-extends prod_q to ACC_WIDTH and adds it into acc (stage 2).
  - Fire on tap nb_taps-1 moves to DRAIN.
- DRAIN: one cycle; last product enters acc; no consumption.
- OUT:
  - y_o.valid=1; y_o.data = sat(acc >>> shift), arithmetic shift, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - data is stable while valid and not ready.
  - On y_o.ready: out_cnt++, acc=0, tap_cnt=0.
  - If out_cnt was nb_outputs-1: IDLE with done_o pulse; otherwise ACC.
- Latency: last pair fire -> y_o.valid 2 cycles later. Throughput: nb_taps+2 cycles per output with no backpressure.
- Accumulator overflow beyond ACC_WIDTH wraps (two's complement); not flagged.
- enable_i low: freezes FSM, pipeline and valid, without dropping data.

Optional Feature:
- Macro FIR_MAC_ENGINE_ROUND_EN.
- Defined: when shift>0, add 2^(shift-1) to acc before the shift (round half up), then saturate.
- Undefined: plain truncating arithmetic shift, then saturate. Behaviour is identical when shift=0.

Test Plan:
- nb_taps=4, nb_outputs=1, shift=0; x={1,2,3,4}, h={1,1,1,1} -> one y=10, done_o pulse, busy_o falls.
- nb_taps=2, shift=0; x={32767,32767}, h={32767,32767} -> y=32767 (positive saturation); x={-32768,-32768}, h={32767,32767} -> y=-32768.
- nb_taps=1, shift=2, x=7, h=1 -> y=1 without the macro, y=2 with it; x=-7, h=1 -> y=-2 both ways.
- nb_taps=3, nb_outputs=4, random valid gaps on x/h, y_o.ready low 5 cycles per output -> 4 correct outputs in order; y data stable while stalled; x/h ready never asserted alone.
- Assert clear_i mid-ACC of a 3-output job, then restart with nb_taps=2, nb_outputs=1, x={2,3}, h={4,5} -> y=23, no stale accumulation, no done_o from the aborted job.
- start_i with nb_taps=0 -> done_o the next cycle, no ready asserted, y_o.valid stays 0.

Source files
------------

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: joint x/h stream multiply-accumulate stage of the FIR.
// Each output consumes nb_taps (x, h) pairs through a two-stage pipeline
// (product register, then accumulator), followed by a shift and a saturation
// to DATA_WIDTH bits.
// Optional build macro FIR_MAC_ENGINE_ROUND_EN: round half up before the shift.
module fir_mac_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    nb_taps_i,
  input  logic [CNT_WIDTH-1:0]    nb_outputs_i,
  input  logic [4:0]              shift_i,
  input  logic                    x_valid_i,
  input  logic [DATA_WIDTH-1:0]   x_data_i,
  output logic                    x_ready_o,
  input  logic                    h_valid_i,
  input  logic [DATA_WIDTH-1:0]   h_data_i,
  output logic                    h_ready_o,
  output logic                    y_valid_o,
  output logic [DATA_WIDTH-1:0]   y_data_o,
  output logic [DATA_WIDTH/8-1:0] y_strb_o,
  input  logic                    y_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Saturation bounds expressed at the width of the shifted accumulator.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  state_t                         state_reg, state_next;
  logic signed [ACC_WIDTH-1:0]    acc_reg, acc_next;
  logic signed [2*DATA_WIDTH-1:0] prod_reg, prod_next;
  logic                           prod_valid_reg, prod_valid_next;
  logic [CNT_WIDTH-1:0]           tap_cnt_reg, tap_cnt_next;
  logic [CNT_WIDTH-1:0]           out_cnt_reg, out_cnt_next;
  logic [CNT_WIDTH-1:0]           nb_taps_reg, nb_taps_next;
  logic [CNT_WIDTH-1:0]           nb_outputs_reg, nb_outputs_next;
  logic [4:0]                     shift_reg, shift_next;
  logic                           done_reg, done_next;

  logic                           fire;
  logic                           y_fire;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH:0]      acc_ext;
  logic signed [ACC_WIDTH:0]      bias;
  logic signed [ACC_WIDTH:0]      shifted;
  logic [DATA_WIDTH-1:0]          y_sat;

  // x and h are only ever consumed together, and only while accumulating.
  assign fire      = (state_reg == S_ACC) & x_valid_i & h_valid_i & enable_i;
  assign x_ready_o = fire;
  assign h_ready_o = fire;

  // valid is masked by enable so a frozen engine never completes a handshake.
  assign y_valid_o = (state_reg == S_OUT) & enable_i;
  assign y_fire    = y_valid_o & y_ready_i;
  assign y_data_o  = (state_reg == S_OUT) ? y_sat : '0;
  assign busy_o    = (state_reg != S_IDLE);
  assign done_o    = done_reg;

  assign prod_full = (2*DATA_WIDTH)'($signed(x_data_i)) * (2*DATA_WIDTH)'($signed(h_data_i));

  for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_strb
    assign y_strb_o[gi] = 1'b1;
  end

  // Shift the accumulator (one guard bit so rounding cannot wrap) and clamp.
  always_comb begin
    acc_ext = {acc_reg[ACC_WIDTH-1], acc_reg};
    bias    = '0;
`ifdef FIR_MAC_ENGINE_ROUND_EN
    if (shift_reg != 5'd0) bias = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift_reg - 5'd1);
`endif
    shifted = (acc_ext + bias) >>> shift_reg;
    if (shifted > SAT_MAX)      y_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) y_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                        y_sat = shifted[DATA_WIDTH-1:0];
  end

  // Next-state and datapath updates; clear overrides everything.
  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    prod_next       = prod_reg;
    prod_valid_next = 1'b0;
    tap_cnt_next    = tap_cnt_reg;
    out_cnt_next    = out_cnt_reg;
    nb_taps_next    = nb_taps_reg;
    nb_outputs_next = nb_outputs_reg;
    shift_next      = shift_reg;
    done_next       = 1'b0;

    // Stage 2: the product registered last cycle lands in the accumulator.
    if (prod_valid_reg) acc_next = acc_reg + ACC_WIDTH'(prod_reg);

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          nb_taps_next    = nb_taps_i;
          nb_outputs_next = nb_outputs_i;
          shift_next      = shift_i;
          acc_next        = '0;
          tap_cnt_next    = '0;
          out_cnt_next    = '0;
          if (nb_taps_i == '0 || nb_outputs_i == '0) done_next = 1'b1;
          else                                       state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (fire) begin
          prod_next       = prod_full;
          prod_valid_next = 1'b1;
          tap_cnt_next    = tap_cnt_reg + CNT_ONE;
          if (tap_cnt_reg == nb_taps_reg - CNT_ONE) state_next = S_DRAIN;
        end
      end
      S_DRAIN: state_next = S_OUT;
      S_OUT: begin
        if (y_fire) begin
          acc_next     = '0;
          tap_cnt_next = '0;
          out_cnt_next = out_cnt_reg + CNT_ONE;
          if (out_cnt_reg == nb_outputs_reg - CNT_ONE) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ACC;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (clear_i) begin
      state_next      = S_IDLE;
      acc_next        = '0;
      prod_next       = '0;
      prod_valid_next = 1'b0;
      tap_cnt_next    = '0;
      out_cnt_next    = '0;
      nb_taps_next    = '0;
      nb_outputs_next = '0;
      shift_next      = '0;
      done_next       = 1'b0;
    end
  end

  // State and pipeline registers; everything holds while enable is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= S_IDLE;
      acc_reg        <= '0;
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      tap_cnt_reg    <= '0;
      out_cnt_reg    <= '0;
      nb_taps_reg    <= '0;
      nb_outputs_reg <= '0;
      shift_reg      <= '0;
      done_reg       <= 1'b0;
    end else if (enable_i || clear_i) begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      prod_reg       <= prod_next;
      prod_valid_reg <= prod_valid_next;
      tap_cnt_reg    <= tap_cnt_next;
      out_cnt_reg    <= out_cnt_next;
      nb_taps_reg    <= nb_taps_next;
      nb_outputs_reg <= nb_outputs_next;
      shift_reg      <= shift_next;
      done_reg       <= done_next;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Testbench for fir_mac_engine: directed and randomized jobs checked against
// a plain-arithmetic reference (sum of products, shift, optional rounding, clamp).
module tb_fir_mac_engine;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] nb_taps = '0;
  logic [CW-1:0] nb_outputs = '0;
  logic [4:0]    shift = '0;
  logic          x_valid = 1'b0;
  logic          h_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic [DW-1:0] h_data = '0;
  logic          y_ready = 1'b0;
  logic          x_ready_o, h_ready_o, y_valid_o, busy_o, done_o;
  logic [DW-1:0] y_data_o;
  logic [DW/8-1:0] y_strb_o;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fire_cyc = 0;
  int done_cnt = 0;
  int xq[$];
  int hq[$];

  fir_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .start_i(start), .nb_taps_i(nb_taps), .nb_outputs_i(nb_outputs), .shift_i(shift),
    .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready_o),
    .h_valid_i(h_valid), .h_data_i(h_data), .h_ready_o(h_ready_o),
    .y_valid_o(y_valid_o), .y_data_o(y_data_o), .y_strb_o(y_strb_o), .y_ready_i(y_ready),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: wrap the sum to the accumulator width, shift, round, clamp.
  function automatic longint ref_y(input longint sum, input int sh);
    longint v;
    v = (sum <<< (64 - AW)) >>> (64 - AW);
`ifdef FIR_MAC_ENGINE_ROUND_EN
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
`endif
    v = v >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  // Protocol monitor: joint ready, y stability while stalled, done counting.
  bit            stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  always @(negedge clk) begin
    #2;
    if (x_ready_o || h_ready_o)
      check("joint_ready", {x_ready_o, h_ready_o, x_valid, h_valid}, 15);
    if (stall_prev && rst_n) begin
      check("y_stall_valid", y_valid_o, 1);
      check("y_stall_data", y_data_o, data_prev);
    end
    stall_prev = y_valid_o && !y_ready && !clear;
    data_prev  = y_data_o;
    if (done_o) done_cnt++;
  end

  task automatic push_pair(input int xv, input int hv);
    xq.push_back(xv);
    hq.push_back(hv);
  endtask

  task automatic push_random(input int n);
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      r = 16'($urandom); xq.push_back(int'($signed(r)));
      r = 16'($urandom); hq.push_back(int'($signed(r)));
    end
  endtask

  // Called at a negedge; returns at the following negedge with start low.
  task automatic do_start(input int taps, input int outs, input int sh);
    start = 1'b1;
    nb_taps = CW'(taps);
    nb_outputs = CW'(outs);
    shift = 5'(sh);
    @(negedge clk);
    start = 1'b0;
    nb_taps = CW'($urandom);
    nb_outputs = CW'($urandom);
    shift = 5'($urandom);
    check("busy_after_start", busy_o, (taps != 0 && outs != 0) ? 1 : 0);
    check("done_after_start", done_o, (taps == 0 || outs == 0) ? 1 : 0);
  endtask

  task automatic feed(input int n, input int gap_max);
    int w;
    int r;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max)) begin
        r = $urandom_range(2);
        x_valid = (r == 1);
        h_valid = (r == 2);
        x_data = DW'($urandom);
        h_data = DW'($urandom);
        @(negedge clk);
      end
      x_valid = 1'b1;
      h_valid = 1'b1;
      x_data = DW'(xq.pop_front());
      h_data = DW'(hq.pop_front());
      #1;
      w = 0;
      while (!x_ready_o && w < 500) begin
        @(negedge clk); #1; w++;
      end
      if (!x_ready_o) begin
        check("x_fire_timeout", 0, 1);
        x_valid = 1'b0; h_valid = 1'b0;
        return;
      end
      last_fire_cyc = cyc;
      @(negedge clk);
    end
    x_valid = 1'b0;
    h_valid = 1'b0;
  endtask

  task automatic collect(input longint exp, input int stall, input bit last);
    int w;
    y_ready = 1'b0;
    w = 0;
    while (!y_valid_o && w < 500) begin
      @(negedge clk); w++;
    end
    if (!y_valid_o) begin
      check("y_valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc - last_fire_cyc, 2);
    repeat ((stall < 0) ? $urandom_range(3) : stall) @(negedge clk);
    y_ready = 1'b1;
    check("y_valid_at_accept", y_valid_o, 1);
    check("y_data", longint'($signed(y_data_o)), exp);
    $display("[TB] y got %0d expected %0d", $signed(y_data_o), exp);
    @(negedge clk);
    y_ready = 1'b0;
    check("done_after_y", done_o, last ? 1 : 0);
    check("busy_after_y", busy_o, last ? 0 : 1);
  endtask

  task automatic run_job(input int taps, input int outs, input int sh,
                         input int gap_max, input int stall, input bit poke);
    longint exp_y[$];
    longint s;
    for (int o = 0; o < outs; o++) begin
      s = 0;
      for (int t = 0; t < taps; t++)
        s += longint'(xq[o*taps+t]) * longint'(hq[o*taps+t]);
      exp_y.push_back(ref_y(s, sh));
    end
    $display("[TB] job taps=%0d outputs=%0d shift=%0d", taps, outs, sh);
    do_start(taps, outs, sh);
    fork
      feed(taps * outs, gap_max);
      for (int o = 0; o < outs; o++) collect(exp_y[o], stall, o == outs - 1);
      if (poke) begin
        repeat (3) @(negedge clk);
        start = 1'b1; nb_taps = CW'(1); nb_outputs = CW'(1); shift = 5'd7;
        @(negedge clk);
        start = 1'b0;
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Reset state, with upstream valid and downstream ready asserted.
    x_valid = 1'b1; h_valid = 1'b1; y_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x_ready", x_ready_o, 0);
    check("rst_h_ready", h_ready_o, 0);
    check("rst_y_valid", y_valid_o, 0);
    check("rst_y_data", y_data_o, 0);
    check("rst_y_strb", y_strb_o, 3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_n = 1'b1;
    x_valid = 1'b0; h_valid = 1'b0; y_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sum: 1+2+3+4.
    push_pair(1, 1); push_pair(2, 1); push_pair(3, 1); push_pair(4, 1);
    run_job(4, 1, 0, 0, 0, 1'b0);

    // Positive and negative saturation.
    push_pair(32767, 32767); push_pair(32767, 32767);
    run_job(2, 1, 0, 0, 0, 1'b0);
    push_pair(-32768, 32767); push_pair(-32768, 32767);
    run_job(2, 1, 0, 0, 0, 1'b0);

    // Shift with and without rounding.
    push_pair(7, 1);
    run_job(1, 1, 2, 0, 0, 1'b0);
    push_pair(-7, 1);
    run_job(1, 1, 2, 0, 0, 1'b0);

    // Gapped input, stalled output, ignored start mid-job.
    push_random(12);
    run_job(3, 4, 4, 3, 5, 1'b1);

    // Clear mid-accumulation, then a fresh job.
    push_random(9);
    do_start(3, 3, 0);
    feed(2, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", busy_o, 0);
    check("clear_y_valid", y_valid_o, 0);
    xq.delete(); hq.delete();
    dc = done_cnt;
    push_pair(2, 4); push_pair(3, 5);
    run_job(2, 1, 0, 0, 0, 1'b0);
    @(negedge clk); #3;
    check("clear_done_count", done_cnt - dc, 1);

    // Zero-length jobs: immediate done, no traffic.
    x_valid = 1'b1; h_valid = 1'b1; y_ready = 1'b1;
    do_start(0, 2, 0);
    #1;
    check("zero_taps_x_ready", x_ready_o, 0);
    check("zero_taps_y_valid", y_valid_o, 0);
    @(negedge clk); #1;
    check("zero_taps_done_drop", done_o, 0);
    check("zero_taps_x_ready2", x_ready_o, 0);
    @(negedge clk);
    do_start(3, 0, 0);
    #1;
    check("zero_outs_x_ready", x_ready_o, 0);
    check("zero_outs_y_valid", y_valid_o, 0);
    @(negedge clk);
    x_valid = 1'b0; h_valid = 1'b0; y_ready = 1'b0;

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      int taps, outs, sh;
      taps = $urandom_range(5, 1);
      outs = $urandom_range(3, 1);
      sh = $urandom_range(20);
      push_random(taps * outs);
      run_job(taps, outs, sh, 2, -1, 1'b0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
